// File: rtl/reservoir_pkg.sv
// reservoir_pkg: shared state encoding and default sizing for the reservoir scheduler
package reservoir_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam int DEF_CAP = 10000;
  localparam int DEF_CBITS = 14;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick searching upward from ptr with wrap-around
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  // walk offsets from farthest to nearest so the nearest requester from ptr wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx = IW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/reservoir_sched.sv
// reservoir_sched: arbitrates unit-by-unit load/store transfers into a bounded reservoir
module reservoir_sched
  import reservoir_pkg::*;
#(
  parameter int CAP = DEF_CAP,
  parameter int CBITS = DEF_CBITS,
  parameter int NREQ = 4,
  parameter int ABITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  input  logic [NREQ*ABITS-1:0]   amt,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    short,
  output logic [CBITS-1:0]        vol,
  output logic                    full,
  output logic                    empty,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [ABITS-1:0] rem;
  logic [IW-1:0] ptr, win, a_idx;
  logic [NREQ-1:0] a_gnt;
  logic a_any, cur_dir, stop;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(a_gnt),
    .idx(a_idx),
    .any(a_any)
  );
  assign full = vol == CBITS'(CAP);
  assign empty = vol == '0;
  assign busy = state != IDLE;
  // a transfer ends on cancel, exhausted amount, or hitting the relevant reservoir bound
  always_comb stop = !req[win] || rem == '0 || (cur_dir ? full : empty);
  // scheduler FSM: grant, move one unit per edge, then pulse done for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vol <= '0;
      rem <= '0;
      ptr <= '0;
      win <= '0;
      cur_dir <= 1'b0;
      gnt <= '0;
      done <= 1'b0;
      short <= 1'b0;
      done_id <= '0;
    end else begin
      case (state)
        IDLE: if (a_any) begin
          win <= a_idx;
          cur_dir <= dir[a_idx];
          rem <= amt[int'(a_idx)*ABITS +: ABITS];
          gnt <= a_gnt;
          state <= XFER;
        end
        XFER: if (stop) begin
          done <= 1'b1;
          short <= !req[win] || rem != '0;
          done_id <= win;
          state <= DONE;
        end else begin
          vol <= cur_dir ? vol + 1'b1 : vol - 1'b1;
          rem <= rem - 1'b1;
        end
        DONE: begin
          done <= 1'b0;
          short <= 1'b0;
          gnt <= '0;
          ptr <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reservoir_sched.sv
// tb_reservoir_sched: directed checks of grant order, unit transfer, bounds, cancel and reset
module tb_reservoir_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, dir;
  logic [31:0] amt;
  logic [3:0] gnt, b_gnt;
  logic done, b_done, short, b_short, full, b_full, empty, b_empty, busy, b_busy;
  logic [1:0] done_id, b_done_id;
  logic [13:0] vol, b_vol;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reservoir_sched dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .amt(amt),
    .gnt(gnt), .done(done), .done_id(done_id), .short(short),
    .vol(vol), .full(full), .empty(empty), .busy(busy)
  );
  reservoir_sched #(.CAP(20)) dut_b (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .amt(amt),
    .gnt(b_gnt), .done(b_done), .done_id(b_done_id), .short(b_short),
    .vol(b_vol), .full(b_full), .empty(b_empty), .busy(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    dir = '0;
    amt = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_vol", vol, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    req = 4'b0001; dir = 4'b0001; amt[7:0] = 8'd5;
    tick();
    chk("load_gnt", gnt, 4'b0001);
    chk("load_busy", busy, 1);
    chk("load_vol0", vol, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("load_vol", vol, k);
      chk("load_nodone", done, 0);
    end
    tick();
    chk("load_done", done, 1);
    chk("load_id", done_id, 0);
    chk("load_short", short, 0);
    chk("load_volf", vol, 5);
    req = '0;
    tick();
    chk("load_exit_done", done, 0);
    chk("load_exit_gnt", gnt, 0);
    chk("load_exit_busy", busy, 0);
    do_reset();
    req = 4'b0001; dir = 4'b0001; amt = '0;
    tick();
    chk("zero_gnt", gnt, 4'b0001);
    tick();
    chk("zero_done", done, 1);
    chk("zero_short", short, 0);
    chk("zero_vol", vol, 0);
    req = '0;
    tick();
    do_reset();
    req = 4'b0010; dir = 4'b0000; amt[15:8] = 8'd3;
    tick();
    chk("empty_gnt", gnt, 4'b0010);
    tick();
    chk("empty_done", done, 1);
    chk("empty_short", short, 1);
    chk("empty_id", done_id, 1);
    chk("empty_vol", vol, 0);
    req = '0;
    tick();
    do_reset();
    req = 4'b0001; dir = 4'b0001; amt[7:0] = 8'd18;
    for (int k = 0; k < 20; k++) tick();
    chk("fill_done", b_done, 1);
    chk("fill_vol", b_vol, 18);
    req = '0;
    tick();
    tick();
    req = 4'b0001; amt[7:0] = 8'd10;
    tick();
    chk("full_gnt", b_gnt, 4'b0001);
    tick();
    tick();
    chk("full_vol20", b_vol, 20);
    tick();
    chk("full_done", b_done, 1);
    chk("full_short", b_short, 1);
    chk("full_flag", b_full, 1);
    chk("full_vol", b_vol, 20);
    req = '0;
    for (int k = 0; k < 4; k++) tick();
    do_reset();
    req = 4'b1111; dir = 4'b1111; amt = 32'h01010101;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("rr_gnt", gnt, 4'b0001 << (r % 4));
      tick();
      chk("rr_vol", vol, r + 1);
      tick();
      chk("rr_done", done, 1);
      chk("rr_id", done_id, r % 4);
      tick();
      chk("rr_idle", busy, 0);
    end
    do_reset();
    req = 4'b0100; dir = 4'b0100; amt[23:16] = 8'd50;
    tick();
    chk("cancel_gnt", gnt, 4'b0100);
    for (int k = 0; k < 7; k++) tick();
    chk("cancel_vol7", vol, 7);
    req = '0;
    tick();
    chk("cancel_done", done, 1);
    chk("cancel_short", short, 1);
    chk("cancel_id", done_id, 2);
    chk("cancel_vol", vol, 7);
    tick();
    do_reset();
    req = 4'b0001; dir = 4'b0001; amt[7:0] = 8'd50;
    tick();
    tick();
    tick();
    tick();
    chk("mid_vol3", vol, 3);
    rst = 1'b1;
    tick();
    chk("mid_gnt", gnt, 0);
    chk("mid_vol", vol, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    rst = 1'b0;
    req = '0;
    tick();
    chk("mid_nodone", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
